// File: rtl/img_pkg.sv
// Shared image-path constants and the stream writer state encoding.
package img_pkg;

  localparam int IMG_W     = 160;
  localparam int IMG_H     = 120;
  localparam int IMG_DEPTH = 19200;
  localparam int IMG_AW    = 15;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } wr_state_t;

endpackage

// File: rtl/img_addr_wrap.sv
// Image address increment that wraps at the last RAM word.
import img_pkg::*;

module img_addr_wrap #(
  parameter int DEPTH = IMG_DEPTH,
  parameter int AW    = IMG_AW
) (
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] o_next
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Out-of-range start addresses fall back to 0 on the first step.
  assign o_next = (i_addr >= LAST) ? '0 : i_addr + 1'b1;

endmodule

// File: rtl/img_stream_writer.sv
// Byte stream to image-RAM Avalon-MM writer; one write per pixel.
// Define IMG_WRITER_CHECKSUM_EN to enable the running 16-bit checksum.
import img_pkg::*;

module img_stream_writer #(
  parameter int DEPTH = IMG_DEPTH,
  parameter int AW    = IMG_AW,
  parameter int CW    = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] pixel_count,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [AW-1:0] avm_address,
  output logic          avm_chipselect,
  output logic          avm_write,
  output logic [7:0]    avm_writedata,
  input  logic          avm_waitrequest,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] written,
  output logic [15:0]   checksum
);

  wr_state_t     r_state;
  wr_state_t     w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_inc;
  logic [CW-1:0] r_remaining;
  logic [CW-1:0] r_accepted;
  logic [CW-1:0] r_written;
  logic [7:0]    r_pend;
  logic          r_pend_v;
  logic          r_abort_seen;
  logic          w_run;
  logic          w_go;
  logic          w_accept;
  logic          w_wr_done;
  logic          w_last;

  img_addr_wrap #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_wrap (
    .i_addr (r_addr),
    .o_next (w_addr_inc)
  );

  assign w_run     = (r_state == RUN);
  assign w_go      = (r_state == IDLE) && start;
  assign s_ready   = w_run && !r_abort_seen
                   && (r_accepted < r_remaining)
                   && (!r_pend_v || !avm_waitrequest);
  assign w_accept  = s_valid && s_ready;
  assign w_wr_done = w_run && r_pend_v && !avm_waitrequest;
  assign w_last    = (r_written == r_remaining - CW'(1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start)
          w_state_nxt = (pixel_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if ((w_wr_done && w_last) || (r_abort_seen && !r_pend_v))
          w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_accepted   <= '0;
      r_written    <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_abort_seen <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_go) begin
        r_addr       <= base_addr;
        r_remaining  <= pixel_count;
        r_accepted   <= '0;
        r_written    <= '0;
        r_abort_seen <= 1'b0;
      end
      if (w_run && abort)
        r_abort_seen <= 1'b1;
      if (w_wr_done) begin
        r_addr    <= w_addr_inc;
        r_written <= r_written + CW'(1);
      end
      // A same-edge accept refills the holding register without a bubble.
      if (w_accept) begin
        r_pend     <= s_data;
        r_pend_v   <= 1'b1;
        r_accepted <= r_accepted + CW'(1);
      end else if (w_wr_done) begin
        r_pend_v <= 1'b0;
      end
    end
  end

`ifdef IMG_WRITER_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk) begin
    if (reset)
      r_csum <= '0;
    else if (w_go)
      r_csum <= '0;
    else if (w_wr_done)
      r_csum <= r_csum + {8'd0, r_pend};
  end

  assign checksum = r_csum;
`else
  assign checksum = 16'd0;
`endif

  assign avm_write      = r_pend_v;
  assign avm_chipselect = r_pend_v;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_pend;
  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign written        = r_written;

endmodule

// File: tb/tb_img_stream_writer.sv
// Randomized bench for img_stream_writer against a transfer-level model.
module tb_img_stream_writer;
  import img_pkg::*;

  localparam int DEPTH = IMG_DEPTH;
  localparam int AW    = IMG_AW;
  localparam int CW    = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] pixel_count;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect;
  logic          avm_write;
  logic [7:0]    avm_writedata;
  logic          avm_waitrequest;
  logic          busy;
  logic          done;
  logic [CW-1:0] written;
  logic [15:0]   checksum;

  int n_vec = 0;
  int n_err = 0;

  img_stream_writer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .pixel_count     (pixel_count),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .written         (written),
    .checksum        (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address of the i-th write of a transfer starting at base.
  function automatic int exp_addr(input int base, input int i);
    if (base < DEPTH) return (base + i) % DEPTH;
    return (i == 0) ? base : (i - 1) % DEPTH;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_rdy"},  32'(s_ready), 0);
    check({tag, "_wr"},   32'(avm_write), 0);
    check({tag, "_cs"},   32'(avm_chipselect), 0);
    check({tag, "_adr"},  32'(avm_address), 0);
    check({tag, "_dat"},  32'(avm_writedata), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wrtn"}, 32'(written), 0);
    check({tag, "_csum"}, 32'(checksum), 0);
  endtask

  task automatic run_xfer(input string nm, input int base, input int cnt,
                          input int vprob, input int wprob,
                          input int abort_at, input bit dir_stall,
                          input bit seq);
    logic [7:0] acc_q[$];
    int cyc, done_cyc, ndone, stalls, stall_rem, abort_hold;
    int pred, nwr, k, n, sum;
    bit aborted, prev_stall;
    pred = (wprob == 0 && !dir_stall && abort_at < 0 && vprob == 100)
         ? ((cnt == 0) ? 1 : cnt + 2) : -1;
    base_addr = AW'(base);
    pixel_count = CW'(cnt);
    start = 1'b1;
    s_valid = 1'b0;
    abort = 1'b0;
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    cyc = 1; done_cyc = -1; ndone = 0; stalls = 0; stall_rem = 3;
    abort_hold = 0; nwr = 0; aborted = 0; prev_stall = 0;
    while (1) begin
      start = 1'b0;
      abort = 1'b0;
      if (done_cyc >= 0) begin
        s_valid = 1'($urandom_range(0, 1));
        avm_waitrequest = 1'b0;
      end else begin
        s_valid = ($urandom_range(1, 100) <= vprob);
        s_data = seq ? 8'(17 * (acc_q.size() + 1)) : 8'($urandom);
        // start outside IDLE (including the DONE cycle) must be ignored
        if (pred >= 0 && cyc == pred) start = 1'b1;
        else if ($urandom_range(0, 19) == 0) begin
          start = 1'b1;
          base_addr = AW'($urandom);
          pixel_count = CW'($urandom);
        end
        if (abort_at >= 0 && !aborted && acc_q.size() == abort_at) begin
          abort = 1'b1;
          s_valid = 1'b0;
          aborted = 1;
          abort_hold = 3;
        end
        if (abort_hold > 0) begin
          avm_waitrequest = 1'b1;
          abort_hold--;
        end else if (dir_stall && nwr == 1 && avm_write && stall_rem > 0) begin
          avm_waitrequest = 1'b1;
          stall_rem--;
        end else begin
          avm_waitrequest = ($urandom_range(1, 100) <= wprob);
        end
      end
      @(negedge clk);
      if (done_cyc >= 0) break;
      if (prev_stall) check({nm, "_hold_wr"}, 32'(avm_write), 1);
      prev_stall = avm_write && avm_waitrequest;
      if (prev_stall) begin
        stalls++;
        check({nm, "_stall_rdy"}, 32'(s_ready), 0);
      end
      if (avm_write) begin
        k = nwr;
        check({nm, "_cs"}, 32'(avm_chipselect), 1);
        if (k < acc_q.size()) begin
          check({nm, "_addr"}, 32'(avm_address), exp_addr(base, k));
          check({nm, "_data"}, 32'(avm_writedata), 32'(acc_q[k]));
        end else begin
          check({nm, "_extra_wr"}, 32'(avm_write), 0);
        end
        if (!avm_waitrequest) nwr++;
      end
      if (s_valid && s_ready) acc_q.push_back(s_data);
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (cyc >= 1000) begin
        check({nm, "_timeout"}, 32'(done), 1);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n = acc_q.size();
    sum = 0;
    foreach (acc_q[i]) sum += int'(acc_q[i]);
    check({nm, "_post_busy"}, 32'(busy), 0);
    check({nm, "_post_done"}, 32'(done), 0);
    check({nm, "_ndone"}, ndone, 1);
    check({nm, "_nacc"}, n, (abort_at >= 0) ? abort_at : cnt);
    check({nm, "_nwr"}, nwr, n);
    check({nm, "_written"}, 32'(written), n);
`ifdef IMG_WRITER_CHECKSUM_EN
    check({nm, "_csum"}, 32'(checksum), sum & 32'hFFFF);
`else
    check({nm, "_csum"}, 32'(checksum), 0);
`endif
    if (pred >= 0)
      check({nm, "_lat"}, done_cyc, pred);
    else if (abort_at < 0 && vprob == 100 && cnt > 0)
      check({nm, "_lat"}, done_cyc, cnt + 2 + stalls);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    pixel_count = '0;
    s_valid = 1'b0;
    s_data = '0;
    avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    run_xfer("basic", 0, 4, 100, 0, -1, 0, 1);
    run_xfer("wrap", 19198, 3, 100, 0, -1, 0, 0);
    run_xfer("oor", 20000, 3, 100, 0, -1, 0, 0);
    run_xfer("stall", 50, 4, 100, 0, -1, 1, 0);
    run_xfer("zero", 7, 0, 100, 0, -1, 0, 0);
    run_xfer("abort", 200, 10, 100, 0, 2, 0, 0);

    // Reset while a write is stalled on the bus.
    base_addr = AW'(100);
    pixel_count = CW'(5);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(posedge clk); #1;
    avm_waitrequest = 1'b1;
    @(negedge clk);
    check("rst_pre_wr", 32'(avm_write), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s_valid = 1'b0;
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1;
    run_xfer("after_rst", 300, 6, 100, 0, -1, 0, 0);

    for (int t = 0; t < 12; t++) begin
      int b, c, ab, vp;
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32767))
                                      : int'($urandom_range(DEPTH - 40, DEPTH - 1));
      c = $urandom_range(1, 40);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      vp = ($urandom_range(0, 1) == 0) ? 100 : int'($urandom_range(30, 99));
      run_xfer($sformatf("rnd%0d", t), b, c, vp,
               $urandom_range(0, 50), ab, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
